// File: rtl/joy_db15_tx.sv
// DB15 joystick serialiser: presents {joystick2, joystick1} to an external reader
// that strobes joy_load low to latch and then clocks the bits out on joy_clk.
`timescale 1ns/1ps

module joy_db15_tx #(
    parameter int SYNC_STAGES = 2,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        joy_clk,
    input  logic        joy_load,
    input  logic [15:0] joystick1,
    input  logic [15:0] joystick2,
    output logic        joy_data,
    output logic [5:0]  bit_cnt,
    output logic        frame_done
);

    typedef enum logic {
        ST_LOAD  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam logic        IDLE      = ACTIVE_LOW;
    localparam logic [31:0] IDLE_FILL = {32{IDLE}};
    localparam logic [5:0]  CNT_MAX   = 6'd32;

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] load_sync;
    logic                   sclk;
    logic                   sload;
    logic                   sclk_prev;
    logic                   sclk_rise;
    state_t                 state;

    logic [31:0] shift_reg;
    logic [31:0] shift_next;
    logic [5:0]  cnt_next;
    logic        done_next;

    assign sclk  = clk_sync[SYNC_STAGES-1];
    assign sload = load_sync[SYNC_STAGES-1];

    // Synchronisers and edge history reset high so releasing reset never looks like an edge.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync  <= '1;
            load_sync <= '1;
            sclk_prev <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], joy_clk};
            load_sync <= {load_sync[SYNC_STAGES-2:0], joy_load};
            sclk_prev <= sclk;
        end
    end

    always_comb begin
        state      = state_t'(sload);
        sclk_rise  = sclk & ~sclk_prev;
        shift_next = shift_reg;
        cnt_next   = bit_cnt;
        done_next  = 1'b0;
        case (state)
            ST_LOAD: begin
                // Load wins over a coincident shift clock.
                shift_next = {joystick2, joystick1} ^ IDLE_FILL;
                cnt_next   = '0;
            end
            ST_SHIFT: begin
                if (sclk_rise) begin
                    shift_next = {IDLE, shift_reg[31:1]};
                    if (bit_cnt != CNT_MAX) begin
                        cnt_next  = bit_cnt + 6'd1;
                        done_next = (bit_cnt == CNT_MAX - 6'd1);
                    end
                end
            end
            default: begin
                shift_next = shift_reg;
            end
        endcase
    end

    // joy_data tracks the next bit 0 so it lands in the same cycle as the shift.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            shift_reg  <= IDLE_FILL;
            joy_data   <= IDLE;
            bit_cnt    <= '0;
            frame_done <= 1'b0;
        end else begin
            shift_reg  <= shift_next;
            joy_data   <= shift_next[0];
            bit_cnt    <= cnt_next;
            frame_done <= done_next;
        end
    end

endmodule

// File: tb/tb_joy_db15_tx.sv
// Self-checking bench for joy_db15_tx: an active-low and an active-high instance
// share stimulus and are compared against a frame-level reference model.
`timescale 1ns/1ps

module tb_joy_db15_tx;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        joy_clk;
    logic        joy_load;
    logic [15:0] joystick1;
    logic [15:0] joystick2;
    logic        joy_data,   joy_data_al0;
    logic [5:0]  bit_cnt,    bit_cnt_al0;
    logic        frame_done, frame_done_al0;

    always #10 clk_sys = ~clk_sys;

    joy_db15_tx #(.SYNC_STAGES(2), .ACTIVE_LOW(1'b1)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .joy_clk(joy_clk), .joy_load(joy_load),
        .joystick1(joystick1), .joystick2(joystick2),
        .joy_data(joy_data), .bit_cnt(bit_cnt), .frame_done(frame_done)
    );

    joy_db15_tx #(.SYNC_STAGES(2), .ACTIVE_LOW(1'b0)) dut_al0 (
        .clk_sys(clk_sys), .reset_n(reset_n), .joy_clk(joy_clk), .joy_load(joy_load),
        .joystick1(joystick1), .joystick2(joystick2),
        .joy_data(joy_data_al0), .bit_cnt(bit_cnt_al0), .frame_done(frame_done_al0)
    );

    int compared   = 0;
    int mismatched = 0;

    // Reference model: the latched frame, shifts seen since load/reset, frames completed.
    logic [31:0] frame_bits = '0;
    int          shifts     = 0;
    bit          valid      = 1'b0;
    int          exp_done   = 0;
    int          done_seen     = 0;
    int          done_seen_al0 = 0;

    always @(posedge clk_sys) begin
        if (frame_done === 1'b1)     done_seen++;
        if (frame_done_al0 === 1'b1) done_seen_al0++;
    end

    initial begin
        #1500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic exp_data(input bit al);
        if (!valid || shifts >= 32) return al;
        return frame_bits[shifts] ^ al;
    endfunction

    function automatic int exp_cnt();
        return (shifts > 32) ? 32 : shifts;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, "/data"},     32'(joy_data),     32'(exp_data(1'b1)));
        checkOutput({tag, "/data_al0"}, 32'(joy_data_al0), 32'(exp_data(1'b0)));
        checkOutput({tag, "/cnt"},      32'(bit_cnt),      exp_cnt());
        checkOutput({tag, "/cnt_al0"},  32'(bit_cnt_al0),  exp_cnt());
        checkOutput({tag, "/done"},     done_seen,         exp_done);
        checkOutput({tag, "/done_al0"}, done_seen_al0,     exp_done);
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic applyStimulus(input logic clk_v, input logic load_v, input int cycles);
        joy_clk  = clk_v;
        joy_load = load_v;
        waitCycles(cycles);
    endtask

    task automatic doLoad(input string tag);
        applyStimulus(1'b0, 1'b0, 6);
        valid      = 1'b1;
        shifts     = 0;
        frame_bits = {joystick2, joystick1};
        checkAll({tag, "/load"});
        applyStimulus(1'b0, 1'b1, 6);
    endtask

    task automatic doEdge(input string tag);
        applyStimulus(1'b1, joy_load, 5);
        if (joy_load) begin
            if (shifts == 31) exp_done++;
            shifts++;
        end else begin
            frame_bits = {joystick2, joystick1};
        end
        applyStimulus(1'b0, joy_load, 5);
        checkAll(tag);
    endtask

    initial begin
        int   d0;
        logic old_d, old_d0, new_d, new_d0;

        reset_n   = 1'b0;
        joy_clk   = 1'b0;
        joy_load  = 1'b1;
        joystick1 = '0;
        joystick2 = '0;
        waitCycles(3);
        checkAll("reset");
        checkOutput("reset/frame_done", 32'(frame_done), 32'd0);
        reset_n = 1'b1;
        waitCycles(4);

        // Full frame with one button at each end.
        joystick1 = 16'h0001;
        joystick2 = 16'h8000;
        doLoad("full");
        for (int i = 0; i < 32; i++) doEdge("full");
        checkOutput("full/cnt_end", 32'(bit_cnt), 32'd32);

        // Over-clocking past the end of the frame.
        joystick1 = '0;
        joystick2 = '0;
        doLoad("over");
        d0 = done_seen;
        for (int i = 0; i < 40; i++) doEdge("over");
        checkOutput("over/one_done", done_seen - d0, 32'd1);

        // Exact latency of one shift, and a falling edge changing nothing.
        joystick1 = 16'h0002;
        joystick2 = 16'($urandom);
        doLoad("lat");
        old_d  = exp_data(1'b1);
        old_d0 = exp_data(1'b0);
        shifts = 1;
        new_d  = exp_data(1'b1);
        new_d0 = exp_data(1'b0);
        joy_clk = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            waitCycles(1);
            checkOutput($sformatf("lat/c%0d", c),     32'(joy_data),     32'((c < 3) ? old_d  : new_d));
            checkOutput($sformatf("lat_al0/c%0d", c), 32'(joy_data_al0), 32'((c < 3) ? old_d0 : new_d0));
        end
        joy_clk = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            waitCycles(1);
            checkOutput($sformatf("fall/c%0d", c), 32'(joy_data), 32'(new_d));
            checkOutput($sformatf("fall/cnt%0d", c), 32'(bit_cnt), 32'd1);
        end

        // Clock edges while load is held low; the register keeps tracking inputs.
        joystick1 = 16'($urandom);
        joystick2 = 16'($urandom);
        applyStimulus(1'b0, 1'b0, 6);
        valid      = 1'b1;
        shifts     = 0;
        frame_bits = {joystick2, joystick1};
        for (int i = 0; i < 3; i++) doEdge("coll");
        joystick1 = ~joystick1;
        doEdge("coll_track");
        // Load falling and clock rising in the same cycle.
        applyStimulus(1'b0, 1'b1, 6);
        joystick1 = 16'($urandom) | 16'h0001;
        applyStimulus(1'b1, 1'b0, 6);
        frame_bits = {joystick2, joystick1};
        shifts     = 0;
        checkAll("coll_same");
        applyStimulus(1'b0, 1'b0, 4);
        applyStimulus(1'b0, 1'b1, 6);
        // Inputs changing after the load edge do not disturb the frame.
        joystick1 = ~joystick1;
        joystick2 = 16'($urandom);
        for (int i = 0; i < 32; i++) doEdge("freeze");

        // Reset in the middle of a frame.
        joystick1 = 16'($urandom);
        joystick2 = 16'($urandom);
        doLoad("rst");
        for (int i = 0; i < 10; i++) doEdge("rst_pre");
        d0 = done_seen;
        #5 reset_n = 1'b0;
        valid  = 1'b0;
        shifts = 0;
        #1;
        checkOutput("rst_mid/data_async", 32'(joy_data), 32'd1);
        checkOutput("rst_mid/cnt_async",  32'(bit_cnt),  32'd0);
        waitCycles(3);
        checkAll("rst_mid");
        checkOutput("rst_mid/no_done", done_seen - d0, 32'd0);
        reset_n = 1'b1;
        waitCycles(4);
        for (int i = 0; i < 5; i++) doEdge("post_rst");

        // Active-high instance with only player 2 pressed.
        joystick1 = 16'h0000;
        joystick2 = 16'hFFFF;
        doLoad("al0");
        for (int i = 0; i < 34; i++) doEdge("al0");

        // Random frames of random length, occasionally disturbing inputs mid-frame.
        for (int f = 0; f < 8; f++) begin
            int n;
            joystick1 = 16'($urandom);
            joystick2 = 16'($urandom);
            doLoad($sformatf("rnd%0d", f));
            n = $urandom_range(0, 40);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 7) == 0) joystick1 = 16'($urandom);
                doEdge($sformatf("rnd%0d", f));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/joy_db15_tx.md
JOY_DB15_TX -- requirements
Module: joy_db15_tx

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, meaning the flop count of each input synchroniser (legal 2..3).
REQ-002 The block SHALL have parameter ACTIVE_LOW, default 1, meaning a pressed button (input bit 1) is driven on joy_data as 0.
REQ-003 clk_sys  input  1  system clock, 40-50 MHz; the only clock.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 joy_clk  input  1  shift clock from the DB15 reader; asynchronous to clk_sys.
REQ-006 joy_load  input  1  parallel-load strobe from the reader, active-low; asynchronous.
REQ-007 joystick1  input  16  player-1 buttons, active-high, in the reader's bit map.
REQ-008 joystick2  input  16  player-2 buttons, active-high, same map.
REQ-009 joy_data  output  1  serial data to the reader.
REQ-010 bit_cnt  output  6  count of shifts since the last load, 0..32.
REQ-011 frame_done  output  1  one-cycle pulse when the 32nd bit has been shifted out.

Function
REQ-012 joy_clk and joy_load SHALL each pass through a SYNC_STAGES-flop synchroniser reset to 1; the block SHALL use only the synchronised versions (sclk, sload).
REQ-013 A 32-bit shift register SHALL hold {joystick2, joystick1}. Bit 0 is joystick1[0]. When ACTIVE_LOW=1 each bit SHALL be inverted on load.
REQ-014 LOAD state (sload=0): every cycle the block SHALL reload the shift register from the current inputs and clear bit_cnt to 0. joy_data SHALL follow the register's bit 0.
REQ-015 SHIFT state (sload=1): on each clk_sys cycle where sclk goes from 0 to 1 (rising edge detected on the synchronised signal), the register SHALL shift right by one. The idle level (1 if ACTIVE_LOW=1, else 0) enters at bit 31, and bit_cnt increments.
REQ-016 joy_data SHALL be registered. It SHALL change exactly SYNC_STAGES+1 clk_sys cycles after the joy_clk or joy_load edge that caused the change.
REQ-017 A rising edge of sload SHALL freeze the loaded value. Input changes after that edge SHALL NOT affect the frame in progress.
REQ-018 If sload=0 and a sclk rising edge occur in the same cycle, the load SHALL win: no shift, and bit_cnt stays 0.
REQ-019 bit_cnt SHALL saturate at 32. Further sclk edges SHALL keep shifting idle level and SHALL leave bit_cnt at 32.
REQ-020 frame_done SHALL pulse for one cycle in the cycle bit_cnt goes from 31 to 32, and at no other time.
REQ-021 A sclk falling edge SHALL have no effect.
REQ-022 Two sclk rising edges separated by fewer than SYNC_STAGES+1 clk_sys cycles are outside the contract. The reader clocks at no more than 1/8 of clk_sys.
REQ-023 The state is encoded by sload alone. No other FSM state SHALL exist.

Reset
REQ-024 When reset_n=0, all of the following SHALL hold, asynchronously:
- synchronisers = 1
- shift register = all idle level
- joy_data = idle level (1 by default)
- bit_cnt = 0
- frame_done = 0
- edge-detect history = 1, so no spurious edge is seen on release.
REQ-025 Reset asserted mid-frame SHALL abort the frame. After release, joy_data SHALL stay at idle level until the next load.

Verification
REQ-026 Load, then shift the full frame:
- Stimulus: joystick1=16'h0001, joystick2=16'h8000, ACTIVE_LOW=1; pulse joy_load low then high; give 32 joy_clk rising edges.
- Required: joy_data sequence = 0, then 30x 1, then 0.
- Required: frame_done pulses once, on the 32nd edge.
- Required: bit_cnt = 32.
REQ-027 Over-clocking past the frame:
- Stimulus: 40 joy_clk edges after a load, with no buttons pressed.
- Required: joy_data = 1 throughout; bit_cnt saturates at 32; exactly one frame_done.
REQ-028 Latency:
- Stimulus: one joy_clk rising edge.
- Required: joy_data changes exactly 3 clk_sys cycles later (SYNC_STAGES=2).
- Required: a joy_clk falling edge causes no change.
REQ-029 Collision and freeze:
- Stimulus: joy_clk rises while joy_load is low.
- Required: bit_cnt stays 0 and joy_data = bit 0 of the current inputs.
- Stimulus: change joystick1 after joy_load goes high.
- Required: the serial stream still carries the old value.
REQ-030 Reset mid-frame:
- Stimulus: assert reset_n=0 after 10 shifts.
- Required: joy_data = 1, bit_cnt = 0, no frame_done.
- Stimulus: release reset, then 5 joy_clk edges with no load.
- Required: joy_data stays 1.
REQ-031 ACTIVE_LOW=0:
- Stimulus: joystick2 = 16'hFFFF.
- Required: bits 16..31 are shifted out as 1; bits 0..15 and the idle fill are 0.
